// File: rtl/updown_sweep_controller.sv
// Sequencer for a 4-bit up/down counter. It runs the counter through a
// programmed number of lo->hi->lo triangular sweeps and then parks it at lo.
// It also checks every fed-back count against its own expectation and flags
// the first divergence.
module updown_sweep_controller #(
    parameter int CNT_W   = 4,
    parameter int SWEEP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   lo,
    input  logic [CNT_W-1:0]   hi,
    input  logic [SWEEP_W-1:0] sweeps,
    input  logic [CNT_W-1:0]   cnt_in,
    output logic               ctr_reset,
    output logic               ctr_load,
    output logic [CNT_W-1:0]   load_val,
    output logic               dir,
    output logic               busy,
    output logic               sweep_done,
    output logic [SWEEP_W-1:0] sweep_cnt,
    output logic               fault,
    output logic               cfg_err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UP,
        DOWN,
        HOLD
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   lo_r;
    logic [CNT_W-1:0]   hi_r;
    logic [SWEEP_W-1:0] sweeps_r;
    logic [CNT_W-1:0]   exp_cnt;

    logic               can_start;
    logic               accept;
    logic               reject;
    logic               at_hi;
    logic               at_lo;
    logic               mismatch;
    logic [SWEEP_W-1:0] sweep_next;
    logic               last_sweep;

    // Decode of start requests, bound hits and the feedback check.
    always_comb begin
        can_start  = start && ((state == IDLE) || (state == HOLD));
        accept     = can_start && (lo < hi);
        reject     = can_start && !(lo < hi);
        at_hi      = (cnt_in == hi_r);
        at_lo      = (cnt_in == lo_r);
        mismatch   = ((state == UP) || (state == DOWN)) && (cnt_in != exp_cnt);
        sweep_next = sweep_cnt + 1'b1;
        last_sweep = (sweeps_r != '0) && (sweep_next == sweeps_r);
        busy       = (state == LOAD) || (state == UP) || (state == DOWN);
    end

    // Next state and the combinational counter controls; stop and a failed
    // check both override whatever the sweep logic wanted.
    always_comb begin
        state_nxt = state;
        ctr_reset = 1'b0;
        ctr_load  = 1'b0;
        load_val  = '0;
        dir       = 1'b0;
        case (state)
            IDLE: begin
                ctr_reset = 1'b1;
                if (accept) state_nxt = LOAD;
            end
            LOAD: begin
                ctr_load  = 1'b1;
                load_val  = lo_r;
                state_nxt = UP;
            end
            UP: begin
                dir = at_hi;
                if (at_hi) state_nxt = DOWN;
            end
            DOWN: begin
                dir = !at_lo;
                if (at_lo) begin
                    if (last_sweep) begin
                        ctr_load  = 1'b1;
                        load_val  = lo_r;
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = UP;
                    end
                end
            end
            HOLD: begin
                ctr_load = 1'b1;
                load_val = lo_r;
                if (accept) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
        if (mismatch) state_nxt = IDLE;
        if (stop)     state_nxt = IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Run configuration, expected count, sweep progress and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_r       <= '0;
            hi_r       <= '0;
            sweeps_r   <= '0;
            exp_cnt    <= '0;
            sweep_cnt  <= '0;
            fault      <= 1'b0;
            sweep_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            cfg_err    <= 1'b0;
            if (!stop) begin
                if (accept) begin
                    lo_r      <= lo;
                    hi_r      <= hi;
                    sweeps_r  <= sweeps;
                    sweep_cnt <= '0;
                    fault     <= 1'b0;
                end
                if (reject) cfg_err <= 1'b1;
                if (mismatch) begin
                    fault <= 1'b1;
                end else begin
                    case (state)
                        LOAD: exp_cnt <= lo_r;
                        UP:   exp_cnt <= at_hi ? (hi_r - 1'b1) : (exp_cnt + 1'b1);
                        DOWN: begin
                            if (at_lo) begin
                                sweep_cnt <= sweep_next;
                                if (last_sweep) sweep_done <= 1'b1;
                                else            exp_cnt    <= lo_r + 1'b1;
                            end else begin
                                exp_cnt <= exp_cnt - 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_sweep_controller.sv
// Bench for updown_sweep_controller: models the external up/down counter,
// drives table vectors, hand-written corner sequences and random runs, and
// compares against a closed-form triangle-wave reference.
module tb_updown_sweep_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] sweeps;
    logic [3:0] cnt_in;
    logic       ctr_reset;
    logic       ctr_load;
    logic [3:0] load_val;
    logic       dir;
    logic       busy;
    logic       sweep_done;
    logic [3:0] sweep_cnt;
    logic       fault;
    logic       cfg_err;

    logic [3:0] ctr_model;
    logic       force_en;
    logic [3:0] force_val;

    int n_compared = 0;
    int n_failed   = 0;

    typedef struct {
        int lo;
        int hi;
        int sweeps;
        int exp_cfg_err;
        int exp_latency;
        int exp_sweep_cnt;
    } vec_t;

    vec_t vecs[8];

    updown_sweep_controller #(.CNT_W(4), .SWEEP_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .lo        (lo),
        .hi        (hi),
        .sweeps    (sweeps),
        .cnt_in    (cnt_in),
        .ctr_reset (ctr_reset),
        .ctr_load  (ctr_load),
        .load_val  (load_val),
        .dir       (dir),
        .busy      (busy),
        .sweep_done(sweep_done),
        .sweep_cnt (sweep_cnt),
        .fault     (fault),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 4-bit counter: reset beats load, load beats counting.
    always @(posedge clk) begin
        if (ctr_reset)     ctr_model <= 4'd0;
        else if (ctr_load) ctr_model <= load_val;
        else if (dir)      ctr_model <= ctr_model - 4'd1;
        else               ctr_model <= ctr_model + 4'd1;
    end

    assign cnt_in = force_en ? force_val : ctr_model;

    // Reference: k = cycles since the start was accepted (LOAD is k=1).
    function automatic int ref_cnt(int l, int h, int n, int k);
        int d = h - l;
        int p;
        if (k < 2) return l;
        if (n != 0 && k > 2 + 2 * d * n) return l;
        p = (k - 2) % (2 * d);
        return (p <= d) ? l + p : l + 2 * d - p;
    endfunction

    function automatic int ref_busy(int l, int h, int n, int k);
        if (k < 1) return 0;
        if (n == 0) return 1;
        return (k <= 2 + 2 * (h - l) * n) ? 1 : 0;
    endfunction

    function automatic int ref_done(int l, int h, int n, int k);
        return (n != 0 && k == 3 + 2 * (h - l) * n) ? 1 : 0;
    endfunction

    function automatic int ref_sweeps(int l, int h, int n, int k);
        int c;
        if (k < 3) return 0;
        c = (k - 3) / (2 * (h - l));
        if (n != 0 && c > n) c = n;
        return c % 16;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int l, input int h, input int n, input logic st, input logic sp);
        lo     = 4'(l);
        hi     = 4'(h);
        sweeps = 4'(n);
        start  = st;
        stop   = sp;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doStart(input int l, input int h, input int n);
        applyStimulus(l, h, n, 1'b1, 1'b0);
        step();
        applyStimulus(l, h, n, 1'b0, 1'b0);
    endtask

    task automatic doStopToIdle();
        applyStimulus(0, 0, 0, 1'b0, 1'b1);
        step();
        applyStimulus(0, 0, 0, 1'b0, 1'b0);
        step();
    endtask

    task automatic waitForDone(input int k0, output int k);
        k = k0;
        while (sweep_done !== 1'b1 && k < 200) begin
            step();
            k++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " busy"}, int'(busy), 0);
        checkOutput({tag, " sweep_done"}, int'(sweep_done), 0);
        checkOutput({tag, " cfg_err"}, int'(cfg_err), 0);
        checkOutput({tag, " fault"}, int'(fault), 0);
        checkOutput({tag, " sweep_cnt"}, int'(sweep_cnt), 0);
        checkOutput({tag, " load_val"}, int'(load_val), 0);
        checkOutput({tag, " dir"}, int'(dir), 0);
        checkOutput({tag, " ctr_load"}, int'(ctr_load), 0);
        checkOutput({tag, " ctr_reset"}, int'(ctr_reset), 1);
    endtask

    task automatic runAndCompare(input int l, input int h, input int n, input int cycles, input string tag);
        for (int k = 1; k <= cycles; k++) begin
            if (k >= 2) checkOutput($sformatf("%s cnt k=%0d", tag, k), int'(cnt_in), ref_cnt(l, h, n, k));
            checkOutput($sformatf("%s busy k=%0d", tag, k), int'(busy), ref_busy(l, h, n, k));
            checkOutput($sformatf("%s done k=%0d", tag, k), int'(sweep_done), ref_done(l, h, n, k));
            checkOutput($sformatf("%s sweep_cnt k=%0d", tag, k), int'(sweep_cnt), ref_sweeps(l, h, n, k));
            checkOutput($sformatf("%s fault k=%0d", tag, k), int'(fault), 0);
            step();
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        int l;
        int h;
        int n;

        vecs[0] = '{2, 5, 1, 0, 9, 1};
        vecs[1] = '{7, 7, 1, 1, 0, 0};
        vecs[2] = '{9, 3, 2, 1, 0, 0};
        vecs[3] = '{0, 15, 1, 0, 33, 1};
        vecs[4] = '{4, 6, 3, 0, 15, 3};
        vecs[5] = '{0, 1, 2, 0, 7, 2};
        vecs[6] = '{14, 15, 1, 0, 5, 1};
        vecs[7] = '{5, 12, 2, 0, 31, 2};

        force_en  = 1'b0;
        force_val = 4'd0;
        reset     = 1'b1;
        applyStimulus(0, 0, 0, 1'b0, 1'b0);
        repeat (3) step();
        checkResetValues("reset held");
        reset = 1'b0;
        step();
        checkResetValues("after reset");
        checkOutput("after reset cnt", int'(cnt_in), 0);

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            doStart(vecs[i].lo, vecs[i].hi, vecs[i].sweeps);
            if (vecs[i].exp_cfg_err != 0) begin
                checkOutput($sformatf("vec%0d cfg_err", i), int'(cfg_err), 1);
                checkOutput($sformatf("vec%0d busy", i), int'(busy), 0);
                checkOutput($sformatf("vec%0d ctr_reset", i), int'(ctr_reset), 1);
                step();
                checkOutput($sformatf("vec%0d cfg_err low", i), int'(cfg_err), 0);
                checkOutput($sformatf("vec%0d ctr_reset still", i), int'(ctr_reset), 1);
            end else begin
                checkOutput($sformatf("vec%0d cfg_err", i), int'(cfg_err), 0);
                waitForDone(1, k);
                checkOutput($sformatf("vec%0d latency", i), k, vecs[i].exp_latency);
                checkOutput($sformatf("vec%0d busy", i), int'(busy), 0);
                checkOutput($sformatf("vec%0d park", i), int'(cnt_in), vecs[i].lo);
                checkOutput($sformatf("vec%0d sweep_cnt", i), int'(sweep_cnt), vecs[i].exp_sweep_cnt);
                checkOutput($sformatf("vec%0d ctr_load", i), int'(ctr_load), 1);
                step();
                checkOutput($sformatf("vec%0d done pulse", i), int'(sweep_done), 0);
                checkOutput($sformatf("vec%0d hold", i), int'(cnt_in), vecs[i].lo);
                doStopToIdle();
            end
        end

        $display("[TB] full range continuous");
        doStart(0, 15, 0);
        runAndCompare(0, 15, 0, 66, "full");
        doStopToIdle();
        checkOutput("full stop cnt", int'(cnt_in), 0);

        $display("[TB] abort");
        doStart(1, 10, 2);
        k = 0;
        while (cnt_in !== 4'd4 && k < 20) begin
            step();
            k++;
        end
        checkOutput("abort reach", int'(cnt_in), 4);
        applyStimulus(1, 10, 2, 1'b0, 1'b1);
        step();
        applyStimulus(1, 10, 2, 1'b0, 1'b0);
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort ctr_reset", int'(ctr_reset), 1);
        step();
        checkOutput("abort cnt", int'(cnt_in), 0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("abort no done", int'(sweep_done), 0);
            step();
        end
        checkOutput("abort sweep_cnt", int'(sweep_cnt), 0);

        $display("[TB] divergence");
        doStart(1, 8, 1);
        repeat (3) step();
        checkOutput("div pre", int'(cnt_in), 3);
        force_en  = 1'b1;
        force_val = 4'd9;
        step();
        force_en  = 1'b0;
        checkOutput("div fault", int'(fault), 1);
        checkOutput("div busy", int'(busy), 0);
        checkOutput("div ctr_reset", int'(ctr_reset), 1);
        repeat (4) step();
        checkOutput("div sticky", int'(fault), 1);
        applyStimulus(7, 7, 1, 1'b1, 1'b0);
        step();
        applyStimulus(7, 7, 1, 1'b0, 1'b0);
        checkOutput("div bad cfg_err", int'(cfg_err), 1);
        checkOutput("div bad keeps fault", int'(fault), 1);
        doStart(2, 4, 1);
        runAndCompare(2, 4, 1, 12, "postfault");

        $display("[TB] restart and priority");
        applyStimulus(9, 9, 1, 1'b1, 1'b0);
        step();
        applyStimulus(9, 9, 1, 1'b0, 1'b0);
        checkOutput("hold bad cfg_err", int'(cfg_err), 1);
        checkOutput("hold bad ctr_load", int'(ctr_load), 1);
        checkOutput("hold bad ctr_reset", int'(ctr_reset), 0);
        checkOutput("hold bad busy", int'(busy), 0);
        doStart(3, 6, 1);
        checkOutput("restart busy", int'(busy), 1);
        checkOutput("restart load_val", int'(load_val), 3);
        checkOutput("restart ctr_load", int'(ctr_load), 1);
        repeat (2) step();
        applyStimulus(0, 15, 2, 1'b1, 1'b0);
        step();
        applyStimulus(0, 15, 2, 1'b0, 1'b0);
        waitForDone(4, k);
        checkOutput("busy start ignored latency", k, 9);
        checkOutput("busy start ignored park", int'(cnt_in), 3);
        step();
        applyStimulus(1, 9, 1, 1'b1, 1'b1);
        step();
        applyStimulus(1, 9, 1, 1'b0, 1'b0);
        checkOutput("start+stop busy", int'(busy), 0);
        checkOutput("start+stop ctr_reset", int'(ctr_reset), 1);
        checkOutput("start+stop sweep_cnt", int'(sweep_cnt), 1);
        step();
        checkOutput("start+stop cnt", int'(cnt_in), 0);

        $display("[TB] reset mid-run");
        doStart(0, 5, 2);
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkResetValues("mid reset");

        $display("[TB] random runs");
        for (int r = 0; r < 8; r++) begin
            l = int'($urandom_range(0, 14));
            h = int'($urandom_range(l + 1, 15));
            n = int'($urandom_range(1, 3));
            doStart(l, h, n);
            runAndCompare(l, h, n, 3 + 2 * (h - l) * n + 3, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/updown_sweep_controller.md
# updown_sweep_controller

Control stage upstream of the 4-bit binary up/down counter. It drives the counter's reset, load-select, load data and mode inputs, and reads the counter output back. Under its control the counter performs a programmed number of triangular sweeps lo→hi→lo, then parks at lo. It also checks the fed-back count against its own expected value and flags any divergence.

## Interface
- CNT_W, 4, counter width; lo/hi/cnt_in/load_val width.
- SWEEP_W, 4, width of sweep-count request and progress.
- clk  in  1  rising-edge clock, shared with the counter.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request to begin a run; honoured in IDLE and HOLD only.
- stop  in  1  abort; has priority over start and all sweep activity.
- lo  in  CNT_W  lower bound, sampled on accepted start.
- hi  in  CNT_W  upper bound, sampled on accepted start.
- sweeps  in  SWEEP_W  number of sweeps; 0 = continuous.
- cnt_in  in  CNT_W  counter output, fed back.
- ctr_reset  out  1  to counter reset.
- ctr_load  out  1  to counter sel; the counter loads load_val when high.
- load_val  out  CNT_W  to counter in.
- dir  out  1  to counter mode: 0 = up, 1 = down.
- busy  out  1  high in LOAD, UP and DOWN.
- sweep_done  out  1  registered one-cycle pulse when the final sweep completes.
- sweep_cnt  out  SWEEP_W  completed sweeps in the current run.
- fault  out  1  sticky: cnt_in diverged from its expected value.
- cfg_err  out  1  registered one-cycle pulse: start rejected because lo >= hi.

## Operation
- States: IDLE, LOAD, UP, DOWN, HOLD. State, lo_r, hi_r, sweeps_r, exp, sweep_cnt and fault are registers.
- ctr_reset, ctr_load, load_val and dir are combinational from state and cnt_in.
- Reset values: state IDLE; busy=0, sweep_done=0, cfg_err=0, fault=0, sweep_cnt=0, load_val=0, dir=0, ctr_load=0, ctr_reset=1 (IDLE).
- **IDLE**
  - ctr_reset=1, ctr_load=0, dir=0.
  - start with lo<hi: latch lo/hi/sweeps, clear sweep_cnt and fault, go to LOAD.
  - start with lo>=hi: pulse cfg_err, stay in IDLE.
- **LOAD**
  - ctr_reset=0, ctr_load=1, load_val=lo_r.
  - Set exp=lo_r, go to UP.
- **UP**
  - dir = (cnt_in==hi_r).
  - cnt_in==hi_r: go to DOWN, exp=hi_r-1.
  - Otherwise: exp=exp+1.
- **DOWN**
  - dir = (cnt_in!=lo_r).
  - cnt_in==lo_r completes a sweep; sweep_cnt increments (wraps at 2^SWEEP_W in continuous mode).
  - If sweeps_r!=0 and this was sweep sweeps_r: drive ctr_load=1 with load_val=lo_r, go to HOLD, pulse sweep_done.
  - Otherwise: go to UP, exp=lo_r+1.
  - While not at lo: exp=exp-1.
- **HOLD**
  - ctr_load=1, load_val=lo_r each cycle, so the counter stays at lo.
  - start: re-validate and re-latch as in IDLE, go to LOAD.
  - Bad config: pulse cfg_err, stay in HOLD.
- **Check:** in UP and DOWN, cnt_in!=exp sets fault (sticky) and sends the FSM to IDLE next cycle. fault is cleared only by reset or an accepted start.
- **stop:** in any state, go to IDLE next cycle. sweep_done is not pulsed. sweep_cnt holds its value.
- Bounds are inclusive; each bound appears exactly once per turnaround. lo=0, hi=2^CNT_W-1 is legal, and the counter never wraps.

## Timing
- Start accepted at cycle t: LOAD at t+1, cnt_in=lo at t+2 (first UP cycle).
- One sweep takes 2*(hi-lo) cycles from cnt=lo to cnt=lo.
- For the final sweep, HOLD is entered the cycle after cnt_in=lo in DOWN; sweep_done is high in that first HOLD cycle.
- After stop or fault: ctr_reset is high from the next cycle, and cnt_in reads 0 one cycle later.
- reset mid-run: IDLE on the following cycle, all registered outputs at their reset values.

## Test plan
- **Single sweep:** lo=2, hi=5, sweeps=1, start at t. Required: cnt_in from t+2 is 2,3,4,5,4,3,2; sweep_done=1 at t+9; cnt holds 2; busy=0; sweep_cnt=1.
- **Bad config:** start with lo=7, hi=7. Required: cfg_err pulses once; FSM stays in IDLE; ctr_reset stays 1.
- **Full range, continuous:** lo=0, hi=15, sweeps=0. Required: period 30 cycles; no wrap past 15 or below 0; sweep_cnt increments each return to 0.
- **Abort:** stop in UP at cnt=4. Required: IDLE next cycle; cnt_in=0 one cycle later; sweep_done never asserted.
- **Divergence:** force cnt_in to 9 during UP at expected 3. Required: fault=1 and IDLE next cycle; fault persists until the next accepted start.
- **Restart and priority:** start in HOLD re-enters LOAD; start while busy is ignored; start and stop in the same cycle gives stop.
